// File: rtl/rx_medida_7o1.sv
// 7O1 serial receiver with a "ddd#" message parser that publishes a 3-digit BCD measurement.
// Optional parity checking is enabled by defining RX_PARIDADE_CHECK_EN.
module rx_medida_7o1 #(
  parameter int BAUD_DIV = 434
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        entrada_serial,
  output logic [11:0] dados,
  output logic        pronto,
  output logic        erro,
  output logic [3:0]  db_estado
);

  typedef enum logic [3:0] {
    INICIAL     = 4'd0,
    ESPERA_IDLE = 4'd1,
    START       = 4'd2,
    DADOS       = 4'd3,
    PARIDADE    = 4'd4,
    STOP        = 4'd5,
    ENTREGA     = 4'd6
  } estado_t;

  localparam logic [11:0] CONTA_BIT_CHEIO = 12'(BAUD_DIV - 1);
  localparam logic [11:0] CONTA_MEIO_BIT  = 12'(BAUD_DIV / 2 - 1);

  estado_t     estado;
  logic        sync_1, sync_2, linha_ant;
  logic [11:0] conta_baud;
  logic [2:0]  conta_bit;
  logic [6:0]  dado_rx;
  logic [1:0]  num_dig;
  logic [11:0] desloc;
  logic        ch_digito, ch_fim, par_erro;

`ifdef RX_PARIDADE_CHECK_EN
  logic        par_rx;
  // Odd parity: an even number of ones over data plus parity is an error.
  assign par_erro = ~^{dado_rx, par_rx};
`else
  assign par_erro = 1'b0;
`endif

  assign ch_digito = (dado_rx >= 7'h30) && (dado_rx <= 7'h39);
  assign ch_fim    = (dado_rx == 7'h23);
  assign db_estado = estado;

  always_ff @(posedge clock) begin
    if (reset) begin
      estado     <= INICIAL;
      sync_1     <= 1'b1;
      sync_2     <= 1'b1;
      linha_ant  <= 1'b1;
      conta_baud <= '0;
      conta_bit  <= '0;
      dado_rx    <= '0;
      num_dig    <= '0;
      desloc     <= '0;
      dados      <= '0;
      pronto     <= 1'b0;
      erro       <= 1'b0;
`ifdef RX_PARIDADE_CHECK_EN
      par_rx     <= 1'b0;
`endif
    end else begin
      sync_1    <= entrada_serial;
      sync_2    <= sync_1;
      linha_ant <= sync_2;
      pronto    <= 1'b0;
      erro      <= 1'b0;
      case (estado)
        INICIAL: begin
          conta_baud <= '0;
          if (linha_ant && !sync_2) estado <= START;
        end
        START: begin
          if (conta_baud == CONTA_MEIO_BIT) begin
            conta_baud <= '0;
            conta_bit  <= '0;
            estado     <= sync_2 ? INICIAL : DADOS;
          end else begin
            conta_baud <= conta_baud + 12'd1;
          end
        end
        DADOS: begin
          if (conta_baud == CONTA_BIT_CHEIO) begin
            conta_baud <= '0;
            dado_rx    <= {sync_2, dado_rx[6:1]};
            if (conta_bit == 3'd6) estado <= PARIDADE;
            else conta_bit <= conta_bit + 3'd1;
          end else begin
            conta_baud <= conta_baud + 12'd1;
          end
        end
        PARIDADE: begin
          if (conta_baud == CONTA_BIT_CHEIO) begin
            conta_baud <= '0;
`ifdef RX_PARIDADE_CHECK_EN
            par_rx     <= sync_2;
`endif
            estado     <= STOP;
          end else begin
            conta_baud <= conta_baud + 12'd1;
          end
        end
        STOP: begin
          // The message decision is registered here so pronto/erro show up in ENTREGA.
          if (conta_baud == CONTA_BIT_CHEIO) begin
            conta_baud <= '0;
            if (!sync_2) begin
              erro    <= 1'b1;
              num_dig <= '0;
              estado  <= ESPERA_IDLE;
            end else begin
              estado <= ENTREGA;
              if (par_erro) begin
                erro    <= 1'b1;
                num_dig <= '0;
              end else if (ch_digito && num_dig != 2'd3) begin
                desloc  <= {desloc[7:0], dado_rx[3:0]};
                num_dig <= num_dig + 2'd1;
              end else if (ch_fim && num_dig == 2'd3) begin
                dados   <= desloc;
                pronto  <= 1'b1;
                num_dig <= '0;
              end else begin
                erro    <= 1'b1;
                num_dig <= '0;
              end
            end
          end else begin
            conta_baud <= conta_baud + 12'd1;
          end
        end
        ENTREGA: begin
          conta_baud <= '0;
          estado     <= INICIAL;
        end
        ESPERA_IDLE: begin
          // Needs a full bit-time of continuous idle before another start is trusted.
          if (!sync_2) begin
            conta_baud <= '0;
          end else if (conta_baud == CONTA_BIT_CHEIO) begin
            conta_baud <= '0;
            estado     <= INICIAL;
          end else begin
            conta_baud <= conta_baud + 12'd1;
          end
        end
        default: estado <= INICIAL;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_medida_7o1.sv
// Bench for rx_medida_7o1: message-level reference model plus a pulse scoreboard.
module tb_rx_medida_7o1;
  localparam int B = 8;
`ifdef RX_PARIDADE_CHECK_EN
  localparam bit PAR_CHK = 1'b1;
`else
  localparam bit PAR_CHK = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        entrada_serial = 1'b1;
  logic [11:0] dados;
  logic        pronto, erro;
  logic [3:0]  db_estado;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pronto = 0;
  int n_erro = 0;
  logic prev_pulse = 1'b0;

  // Scoreboard entries: {pronto, erro, dados} per expected pulse, with its earliest cycle.
  logic [13:0] exp_q[$];
  int          win_q[$];

  // Reference model state: message-level view.
  int         m_cnt = 0;
  logic [3:0] m_dig[3];
  logic [11:0] m_dados = '0;

  rx_medida_7o1 #(.BAUD_DIV(B)) dut (
    .clock(clock),
    .reset(reset),
    .entrada_serial(entrada_serial),
    .dados(dados),
    .pronto(pronto),
    .erro(erro),
    .db_estado(db_estado)
  );

  // Clock / reset block
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor and scoreboard
  always @(negedge clock) begin
    logic [13:0] e;
    int w;
    if (!reset && (pronto || erro)) begin
      if (pronto) n_pronto++;
      if (erro) n_erro++;
      checks++;
      if (pronto && erro) begin
        failures++;
        $display("FAIL pulse_exclusive: pronto=%b erro=%b, required not both", pronto, erro);
      end
      checks++;
      if (prev_pulse) begin
        failures++;
        $display("FAIL pulse_width: pulse held for a second cycle at cyc=%0d, required 1 cycle", cyc);
      end
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse: pronto=%b erro=%b dados=%h at cyc=%0d, required no pulse",
                 pronto, erro, dados, cyc);
      end else begin
        e = exp_q.pop_front();
        w = win_q.pop_front();
        if ({pronto, erro, dados} !== e) begin
          failures++;
          $display("FAIL pulse_value: got pronto=%b erro=%b dados=%h, required pronto=%b erro=%b dados=%h",
                   pronto, erro, dados, e[13], e[12], e[11:0]);
        end
        checks++;
        if (cyc < w || cyc >= w + B) begin
          failures++;
          $display("FAIL pulse_timing: pulse at cyc=%0d, required within [%0d,%0d)", cyc, w, w + B);
        end
      end
    end
    prev_pulse = pronto || erro;
  end

  // Driver tasks
  task automatic drive_cycles(input logic val, input int n);
    entrada_serial = val;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    drive_cycles(b, B);
  endtask

  task automatic model_reset();
    m_cnt   = 0;
    m_dados = '0;
    exp_q.delete();
    win_q.delete();
  endtask

  // Sends one 7O1 frame and updates the reference model with its expected outcome.
  task automatic send_frame(input logic [6:0] ch, input bit par_bad, input bit stop_bad);
    logic p;
    bit ev_p, ev_e;
    p = (^ch) ? 1'b0 : 1'b1;
    if (par_bad) p = ~p;
    ev_p = 1'b0;
    ev_e = 1'b0;
    if (stop_bad || (PAR_CHK && par_bad)) begin
      ev_e = 1'b1; m_cnt = 0;
    end else if (ch >= 7'h30 && ch <= 7'h39 && m_cnt < 3) begin
      m_dig[m_cnt] = 4'(ch - 7'h30);
      m_cnt++;
    end else if (ch == 7'h23 && m_cnt == 3) begin
      ev_p = 1'b1;
      m_dados = {m_dig[0], m_dig[1], m_dig[2]};
      m_cnt = 0;
    end else begin
      ev_e = 1'b1; m_cnt = 0;
    end
    if (ev_p || ev_e) begin
      exp_q.push_back({ev_p, ev_e, m_dados});
      win_q.push_back(cyc + 9 * B);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(ch[i]);
    drive_bit(p);
    drive_bit(stop_bad ? 1'b0 : 1'b1);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_frame(7'(s[i]), 1'b0, 1'b0);
  endtask

  // Scenario tasks
  task automatic test_reset();
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (dados !== 12'h000) begin failures++; $display("FAIL reset_dados: got %h, required 000", dados); end
    checks++; if (pronto !== 1'b0) begin failures++; $display("FAIL reset_pronto: got %b, required 0", pronto); end
    checks++; if (erro !== 1'b0) begin failures++; $display("FAIL reset_erro: got %b, required 0", erro); end
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL reset_estado: got %0d, required 0", db_estado); end
    reset = 1'b0;
    model_reset();
    drive_cycles(1'b1, 2 * B);
  endtask

  task automatic test_message();
    int p0, e0;
    p0 = n_pronto; e0 = n_erro;
    send_str("123#");
    checks++; if (dados !== 12'h123) begin failures++; $display("FAIL msg_dados: got %h, required 123", dados); end
    checks++; if (n_pronto - p0 != 1) begin failures++; $display("FAIL msg_pronto_count: got %0d, required 1", n_pronto - p0); end
    checks++; if (n_erro - e0 != 0) begin failures++; $display("FAIL msg_erro_count: got %0d, required 0", n_erro - e0); end
  endtask

  task automatic test_short_message();
    int e0;
    e0 = n_erro;
    send_str("45#");
    checks++; if (n_erro - e0 != 1) begin failures++; $display("FAIL short_erro_count: got %0d, required 1", n_erro - e0); end
    checks++; if (dados !== 12'h123) begin failures++; $display("FAIL short_dados_kept: got %h, required 123", dados); end
    send_str("678#");
    checks++; if (dados !== 12'h678) begin failures++; $display("FAIL after_short_dados: got %h, required 678", dados); end
  endtask

  task automatic test_parity();
    int e0;
    e0 = n_erro;
    send_frame(7'h37, 1'b1, 1'b0);
    send_str("89#");
    checks++; if (dados !== m_dados) begin failures++; $display("FAIL parity_dados: got %h, required %h", dados, m_dados); end
    checks++; if (n_erro - e0 != (PAR_CHK ? 2 : 0)) begin failures++; $display("FAIL parity_erro_count: got %0d, required %0d", n_erro - e0, PAR_CHK ? 2 : 0); end
  endtask

  task automatic test_framing();
    int e0;
    e0 = n_erro;
    send_frame(7'h39, 1'b0, 1'b1);
    // Early start attempt right after the line returns high: must be ignored.
    drive_cycles(1'b1, 3);
    drive_cycles(1'b0, B);
    drive_cycles(1'b1, 12 * B);
    checks++; if (n_erro - e0 != 1) begin failures++; $display("FAIL framing_erro_count: got %0d, required 1", n_erro - e0); end
    send_str("100#");
    checks++; if (dados !== 12'h100) begin failures++; $display("FAIL framing_recover_dados: got %h, required 100", dados); end
  endtask

  task automatic test_reset_mid_frame();
    int p0, e0;
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    drive_bit(1'b0);
    p0 = n_pronto; e0 = n_erro;
    reset = 1'b1;
    entrada_serial = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    checks++; if (dados !== 12'h000) begin failures++; $display("FAIL midreset_dados: got %h, required 000", dados); end
    checks++; if (db_estado !== 4'd0) begin failures++; $display("FAIL midreset_estado: got %0d, required 0", db_estado); end
    reset = 1'b0;
    model_reset();
    drive_cycles(1'b1, 12 * B);
    checks++; if ({pronto, erro} !== 2'b00) begin failures++; $display("FAIL midreset_outputs: got pronto=%b erro=%b, required 0 0", pronto, erro); end
    checks++; if (n_pronto + n_erro != p0 + e0) begin failures++; $display("FAIL midreset_pulses: got %0d, required 0", n_pronto + n_erro - p0 - e0); end
    send_str("005#");
    checks++; if (dados !== 12'h005) begin failures++; $display("FAIL midreset_recover_dados: got %h, required 005", dados); end
    checks++; if (n_pronto - p0 != 1) begin failures++; $display("FAIL midreset_pronto_count: got %0d, required 1", n_pronto - p0); end
  endtask

  task automatic test_invalid_and_glitch();
    int p0, e0;
    e0 = n_erro;
    send_str("12A");
    checks++; if (n_erro - e0 != 1) begin failures++; $display("FAIL invalid_char_erro: got %0d, required 1", n_erro - e0); end
    p0 = n_pronto; e0 = n_erro;
    drive_cycles(1'b0, 1);
    drive_cycles(1'b1, 12 * B);
    checks++; if (n_pronto + n_erro != p0 + e0) begin failures++; $display("FAIL glitch_pulses: got %0d, required 0", n_pronto + n_erro - p0 - e0); end
    checks++; if (dados !== 12'h005) begin failures++; $display("FAIL glitch_dados: got %h, required 005", dados); end
  endtask

  task automatic test_back_to_back_random();
    logic [6:0] ch;
    bit pb, sb;
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) ch = 7'(7'h30 + $urandom_range(0, 9));
      else if (r <= 7) ch = 7'h23;
      else ch = 7'($urandom_range(0, 127));
      pb = ($urandom_range(0, 7) == 0);
      sb = ($urandom_range(0, 11) == 0);
      send_frame(ch, pb, sb);
      if (sb) drive_cycles(1'b1, 2 * B);
    end
    drive_cycles(1'b1, 2 * B);
    checks++; if (dados !== m_dados) begin failures++; $display("FAIL random_dados: got %h, required %h", dados, m_dados); end
  endtask

  initial begin
    test_reset();
    test_message();
    test_short_message();
    test_parity();
    test_framing();
    test_reset_mid_frame();
    test_invalid_and_glitch();
    test_back_to_back_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL missing_pulses: %0d expected pulses never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
